ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 108 ++++++++++
 tb/tb_ps2_key_decoder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard frame receiver tracking the scan code of the held key.
// Define PS2_PARITY_CHECK_EN to reject frames whose data+parity bits are not odd.
module ps2_key_decoder #(
    parameter int CLOCK_FREQUENCY = 25000000
) (
    input  logic       Clock,
    input  logic       reset,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic [7:0] heldData,
    output logic       newKey,
    output logic       frameError
);
    localparam int LIMIT = CLOCK_FREQUENCY / 1000;
    localparam int TW = $clog2(LIMIT + 1);
`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_CHECK = 1'b1;
`else
    localparam logic PARITY_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_next;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev;
    logic [7:0]    shift_reg, rx_byte;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] timer;
    logic          rx_valid, brk, ext;
    logic          fall, dat, timeout, frame_ok, stop_edge, is_e0, is_f0;

    assign fall      = clk_prev & ~clk_sync[1];
    assign dat       = dat_sync[1];
    // Timer holds the count of edge-free cycles already elapsed, so this fires on the one past LIMIT
    assign timeout   = (state != IDLE) && !fall && (timer == TW'(LIMIT));
    assign frame_ok  = dat && (!PARITY_CHECK || ^{parity_bit, shift_reg});
    assign stop_edge = fall && (state == STOP);
    assign is_e0     = rx_byte == 8'hE0;
    assign is_f0     = rx_byte == 8'hF0;

    always_comb begin
        state_next = state;
        if (timeout)
            state_next = IDLE;
        else if (fall)
            case (state)
                IDLE:    state_next = dat ? IDLE : DATA;
                DATA:    state_next = (bit_cnt == 3'd7) ? PARITY : DATA;
                PARITY:  state_next = STOP;
                default: state_next = IDLE;
            endcase
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            timer      <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            frameError <= 1'b0;
        end else begin
            state      <= state_next;
            clk_sync   <= {clk_sync[0], PS2_CLK};
            dat_sync   <= {dat_sync[0], PS2_DAT};
            clk_prev   <= clk_sync[1];
            timer      <= (state == IDLE || fall || timeout) ? '0 : timer + 1'b1;
            rx_valid   <= stop_edge && frame_ok;
            frameError <= timeout || (stop_edge && !frame_ok);
            if (fall && state == IDLE)
                bit_cnt <= '0;
            if (fall && state == DATA) begin
                shift_reg <= {dat, shift_reg[7:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end
            if (fall && state == PARITY)
                parity_bit <= dat;
            if (stop_edge)
                rx_byte <= shift_reg;
        end
    end

    // Prefix bytes only touch the flags; a code byte clears both and then acts as make or break
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            heldData <= 8'h00;
            newKey   <= 1'b0;
            brk      <= 1'b0;
            ext      <= 1'b0;
        end else begin
            newKey <= rx_valid && !is_e0 && !is_f0 && !brk && (rx_byte != 8'h00);
            if (rx_valid) begin
                brk <= is_f0 || (brk && is_e0);
                ext <= is_e0 || (ext && is_f0);
                if (!is_e0 && !is_f0)
                    heldData <= brk ? ((rx_byte == heldData) ? 8'h00 : heldData)
                                    : ((rx_byte != 8'h00) ? rx_byte : heldData);
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: random and directed PS/2 frames checked against a held-key model.
module tb_ps2_key_decoder;
    localparam int FREQ = 2000000;
    localparam int LIMIT = FREQ / 1000;
    localparam int H = 15;
`ifdef PS2_PARITY_CHECK_EN
    localparam logic PARITY_ON = 1'b1;
`else
    localparam logic PARITY_ON = 1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, kclk = 1'b1, kdat = 1'b1;
    wire ps2_clk = kclk;
    wire ps2_dat = kdat;
    logic [7:0] held;
    logic new_key, frame_err;

    int checks = 0, passes = 0, nk_cnt = 0, fe_cnt = 0;
    logic chk_en = 1'b0;
    logic [7:0] m_held = 8'h00;
    logic m_brk = 1'b0;

    ps2_key_decoder #(.CLOCK_FREQUENCY(FREQ)) dut (
        .Clock(clk), .reset(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
        .heldData(held), .newKey(new_key), .frameError(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) check("heldData", held, m_held);
        if (rst_n) begin
            nk_cnt += int'(new_key);
            fe_cnt += int'(frame_err);
        end
    end

    task automatic model_byte(input logic [7:0] b, output logic nk);
        nk = 1'b0;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b != 8'hE0) begin
            if (m_brk) begin
                if (b == m_held) m_held = 8'h00;
                m_brk = 1'b0;
            end else if (b != 8'h00) begin
                m_held = b;
                nk = 1'b1;
            end
        end
    endtask

    task automatic ps2_bit(input logic b, output int lat);
        kdat = b;
        repeat (H) @(negedge clk);
        kclk = 1'b0;
        lat = 0;
        for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            if (new_key && lat == 0) lat = i;
        end
        kclk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, output int lat);
        int nk0, fe0, d;
        logic ok, nk;
        nk0 = nk_cnt;
        fe0 = fe_cnt;
        ps2_bit(1'b0, d);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], d);
        ps2_bit(~^b ^ bad_par, d);
        chk_en = 1'b0;
        ps2_bit(stop, lat);
        ok = stop && !(PARITY_ON && bad_par);
        nk = 1'b0;
        if (ok) model_byte(b, nk);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("newKey_pulses", nk_cnt - nk0, int'(nk));
        check("frameError_pulses", fe_cnt - fe0, int'(!ok));
    endtask

    task automatic frame(input logic [7:0] b);
        int lat;
        send_frame(b, 1'b0, 1'b1, lat);
    endtask

    initial begin
        int lat, fe0, d, r;
        logic [7:0] b;
        logic [7:0] pool [6] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33};
        repeat (3) @(negedge clk);
        check("reset_heldData", held, 8'h00);
        check("reset_newKey", new_key, 0);
        check("reset_frameError", frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_en = 1'b1;

        send_frame(8'h29, 1'b0, 1'b1, lat);
        check("make29_latency", lat, 4);
        check("make29_held", held, 8'h29);
        frame(8'hF0); frame(8'h29);
        check("break29_held", held, 8'h00);
        frame(8'h29); frame(8'h5A);
        check("last_key_wins", held, 8'h5A);
        frame(8'hF0); frame(8'h29);
        check("break_other_key", held, 8'h5A);
        frame(8'hF0); frame(8'h5A);
        check("break5A_held", held, 8'h00);
        frame(8'hE0); frame(8'h5A);
        check("extended_base_code", held, 8'h5A);
        frame(8'h00);
        check("zero_ignored", held, 8'h5A);
        send_frame(8'h76, 1'b1, 1'b1, lat);
        check("bad_parity_76", held, PARITY_ON ? 8'h5A : 8'h76);

        frame(8'h16); frame(8'hF0);
        fe0 = fe_cnt;
        ps2_bit(1'b0, d);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1, d);
        repeat (LIMIT * 11 / 10) @(negedge clk);
        check("timeout_pulses", fe_cnt - fe0, 1);
        frame(8'h16);
        check("brk_survives_timeout", held, 8'h00);
        frame(8'h16);
        check("after_timeout_16", held, 8'h16);
        send_frame(8'h33, 1'b0, 1'b0, lat);
        check("bad_stop_held", held, 8'h16);

        fe0 = fe_cnt;
        ps2_bit(1'b0, d);
        for (int i = 0; i < 4; i++) ps2_bit(i[0], d);
        kdat = 1'b1;
        repeat (H) @(negedge clk);
        kclk = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        rst_n = 1'b0;
        m_held = 8'h00;
        m_brk = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset_held", held, 8'h00);
        check("midreset_newKey", new_key, 0);
        check("midreset_frameError", frame_err, 0);
        kclk = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (10) @(negedge clk);
        check("midreset_no_error", fe_cnt - fe0, 0);
        frame(8'h5A);
        check("after_reset_5A", held, 8'h5A);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 11);
            b = (r == 0) ? 8'hF0 : (r == 1) ? 8'hE0 : (r == 2) ? m_held :
                (r == 3) ? 8'h00 : (r < 8) ? pool[$urandom_range(0, 5)] : 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                fe0 = fe_cnt;
                ps2_bit(1'b1, d);
                repeat (5) @(negedge clk);
                check("idle_high_bit", fe_cnt - fe0, 0);
            end
            send_frame(b, $urandom_range(0, 7) == 0, $urandom_range(0, 9) != 0, lat);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
